// File: rtl/s4ga_cfg_streamer.sv
// s4ga_cfg_streamer
// Feeds an s4ga LUT fabric with its configuration. Holds the fabric in reset
// for RST_CYCLES cycles, then reads one config record per LUT from an external
// synchronous memory and serializes it onto the SI_W-bit config stream, one
// segment per clock with no gaps, LUT 0..N-1 and then around again.
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset
//   start       pulse: begin reset + stream sequence (only honoured when idle)
//   stop        pulse: finish the current sweep, then return to idle
//   mem_rd      record read strobe
//   mem_addr    LUT index of the record being read
//   mem_rdata   record, valid the cycle after mem_rd:
//               {idx[0],..,idx[K-1],mask}, idx[0] in the MSBs
//   si_o        config segment to the fabric
//   fpga_rst_o  fabric reset
//   busy        high in every state except idle
//   sweep_done  high while the last segment of LUT N-1 is on si_o
module s4ga_cfg_streamer #(
  parameter int N          = 71,
  parameter int K          = 5,
  parameter int SI_W       = 4,
  parameter int RST_CYCLES = N + 1,
  localparam int N_W       = $clog2(N),
  localparam int MASK_W    = 2 ** K,
  localparam int REC_W     = K * N_W + MASK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic             mem_rd,
  output logic [N_W-1:0]   mem_addr,
  input  logic [REC_W-1:0] mem_rdata,
  output logic [SI_W-1:0]  si_o,
  output logic             fpga_rst_o,
  output logic             busy,
  output logic             sweep_done
);

  localparam int IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS = (MASK_W + SI_W - 1) / SI_W;
  localparam int LL        = K * IDX_SEGS + MASK_SEGS;
  localparam int IDX_PW    = IDX_SEGS * SI_W;
  localparam int MASK_PW   = MASK_SEGS * SI_W;
  localparam int PAD_W     = LL * SI_W;
  localparam int S_W       = $clog2(LL);
  localparam int RC_W      = $clog2(RST_CYCLES);

  localparam logic [N_W-1:0]  LAST_N  = N_W'(N - 1);
  localparam logic [S_W-1:0]  LAST_S  = S_W'(LL - 1);
  localparam logic [RC_W-1:0] LAST_RC = RC_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_PRIME0,
    S_PRIME1,
    S_STREAM
  } state_t;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [S_W-1:0]    s_q, s_d;
  logic [PAD_W-1:0]  sh_q, sh_d;
  logic [REC_W-1:0]  nxt_q, nxt_d;
  logic              stop_pend_q, stop_pend_d;
  logic              mem_rd_q, mem_rd_d;
  logic [N_W-1:0]    mem_addr_q, mem_addr_d;
  logic              fpga_rst_q, fpga_rst_d;
  logic              busy_q, busy_d;
  logic              sweep_done_q, sweep_done_d;

  // Re-lay a record so every field starts on a segment boundary: each idx is
  // zero-extended to IDX_SEGS segments and the mask to MASK_SEGS segments,
  // idx[0] first, mask last, most significant segment of each field first.
  function automatic logic [PAD_W-1:0] pad(input logic [REC_W-1:0] rec);
    logic [PAD_W-1:0]   p;
    logic [IDX_PW-1:0]  f;
    logic [MASK_PW-1:0] m;
    p = '0;
    for (int i = 0; i < K; i++) begin
      f = '0;
      f[N_W-1:0] = rec[REC_W-1-i*N_W -: N_W];
      p[PAD_W-1-i*IDX_PW -: IDX_PW] = f;
    end
    m = '0;
    m[MASK_W-1:0] = rec[MASK_W-1:0];
    p[MASK_PW-1:0] = m;
    return p;
  endfunction

  // Next-state logic. The record for LUT n+1 is requested in segment 0 of
  // LUT n and parked in nxt, so the shifter reloads on the last segment
  // without a bubble. Output registers are loaded from the next state, which
  // keeps every output a flop with no path from the inputs.
  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    n_d         = n_q;
    s_d         = s_q;
    sh_d        = sh_q;
    nxt_d       = nxt_q;
    stop_pend_d = stop_pend_q;

    if (state_q != S_IDLE && stop) begin
      stop_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RST;
          rcnt_d      = '0;
          stop_pend_d = 1'b0;
        end
      end
      S_RST: begin
        if (rcnt_q == LAST_RC) begin
          state_d = S_PRIME0;
        end else begin
          rcnt_d = rcnt_q + RC_W'(1);
        end
      end
      S_PRIME0: begin
        state_d = S_PRIME1;
      end
      S_PRIME1: begin
        sh_d    = pad(mem_rdata);
        n_d     = '0;
        s_d     = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        sh_d = sh_q << SI_W;
        s_d  = s_q + S_W'(1);
        if (s_q == S_W'(1)) begin
          nxt_d = mem_rdata;
        end
        if (s_q == LAST_S) begin
          if (n_q == LAST_N && stop_pend_q) begin
            state_d     = S_IDLE;
            sh_d        = '0;
            s_d         = '0;
            n_d         = '0;
            stop_pend_d = 1'b0;
          end else begin
            sh_d = pad(nxt_q);
            s_d  = '0;
            n_d  = (n_q == LAST_N) ? '0 : n_q + N_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_rd_d     = (state_d == S_PRIME0) || (state_d == S_STREAM && s_d == '0);
    mem_addr_d   = '0;
    if (state_d == S_STREAM) begin
      mem_addr_d = (n_d == LAST_N) ? '0 : n_d + N_W'(1);
    end
    fpga_rst_d   = (state_d != S_STREAM);
    busy_d       = (state_d != S_IDLE);
    sweep_done_d = (state_d == S_STREAM) && (n_d == LAST_N) && (s_d == LAST_S);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rcnt_q       <= '0;
      n_q          <= '0;
      s_q          <= '0;
      sh_q         <= '0;
      nxt_q        <= '0;
      stop_pend_q  <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      fpga_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      n_q          <= n_d;
      s_q          <= s_d;
      sh_q         <= sh_d;
      nxt_q        <= nxt_d;
      stop_pend_q  <= stop_pend_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      fpga_rst_q   <= fpga_rst_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  // The shifter is cleared whenever streaming is not active, so its top
  // segment is zero outside STREAM.
  assign si_o       = sh_q[PAD_W-1 -: SI_W];
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign fpga_rst_o = fpga_rst_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;

endmodule
